// File: rtl/rt_ibex_pcs_ctrl.sv
`timescale 1ns/1ps
// Sequencer for the rt-ibex preemptible context-save LIFO: turns irq-ack / mret events
// into push/pop commands. Optional level check: RT_IBEX_PCS_CTRL_LEVEL_CHECK_EN.
module rt_ibex_pcs_ctrl #(
   parameter int unsigned MaxDepth      = 8,
   parameter int unsigned IrqLevelWidth = 8
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic                             irq_ack_i,
   input  logic [IrqLevelWidth-1:0]         irq_level_i,
   input  logic                             mret_i,
   output logic                             push_o,
   output logic                             pop_o,
   output logic                             restore_valid_o,
   output logic                             core_stall_o,
   output logic [$clog2(MaxDepth+1)-1:0]    depth_o,
   output logic [IrqLevelWidth-1:0]         curr_level_o,
   output logic                             overflow_o,
   output logic                             underflow_o
`ifdef RT_IBEX_PCS_CTRL_LEVEL_CHECK_EN
   ,output logic                            level_err_o
`endif
);

   localparam int unsigned DepthW = $clog2(MaxDepth + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SAVE = 2'd1,
      POP  = 2'd2,
      WB   = 2'd3
   } state_e;

   state_e                   state_q, state_d;
   logic [DepthW-1:0]        depth_q, depth_d;
   logic [IrqLevelWidth-1:0] level_stack_q [MaxDepth];
   logic [IrqLevelWidth-1:0] level_stack_d [MaxDepth];
   logic [IrqLevelWidth-1:0] curr_level_q, curr_level_d;
   logic [IrqLevelWidth-1:0] save_level_q, save_level_d;
   logic                     ack_pend_q, ack_pend_d;
   logic [IrqLevelWidth-1:0] ack_pend_level_q, ack_pend_level_d;
   logic                     mret_pend_q, mret_pend_d;
   logic                     overflow_q, overflow_d;
   logic                     underflow_q, underflow_d;
   logic                     level_err_q, level_err_d;

   logic                     dispatch_en_s;
   logic                     serve_ack_s;
   logic                     serve_mret_s;
   logic [IrqLevelWidth-1:0] serve_level_s;

   // Next-state, stack bookkeeping and event dispatch.
   always_comb begin
      state_d          = state_q;
      depth_d          = depth_q;
      level_stack_d    = level_stack_q;
      curr_level_d     = curr_level_q;
      save_level_d     = save_level_q;
      ack_pend_d       = ack_pend_q;
      ack_pend_level_d = ack_pend_level_q;
      mret_pend_d      = mret_pend_q;
      overflow_d       = overflow_q;
      underflow_d      = underflow_q;
      level_err_d      = level_err_q;
      serve_ack_s      = 1'b0;
      serve_mret_s     = 1'b0;
      serve_level_s    = irq_level_i;

      case (state_q)
         IDLE: state_d = IDLE;
         SAVE: begin
            state_d      = IDLE;
            depth_d      = depth_q + DepthW'(1);
            curr_level_d = save_level_q;
            for (int i = 0; i < int'(MaxDepth); i++) begin
               if (depth_q == DepthW'(i)) begin
                  level_stack_d[i] = save_level_q;
               end else begin
                  level_stack_d[i] = level_stack_q[i];
               end
            end
         end
         POP: begin
            state_d      = WB;
            depth_d      = depth_q - DepthW'(1);
            curr_level_d = '0;
            for (int i = 2; i <= int'(MaxDepth); i++) begin
               if (depth_q == DepthW'(i)) begin
                  curr_level_d = level_stack_q[i-2];
               end else begin
                  curr_level_d = curr_level_d;
               end
            end
         end
         WB:      state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Every state whose successor is IDLE may hand off to the next operation
      // directly, judged against the depth/level it leaves behind.
      dispatch_en_s = (state_q != POP);

      if (!dispatch_en_s) begin
         if (irq_ack_i) begin
            ack_pend_d       = 1'b1;
            ack_pend_level_d = irq_level_i;
         end else begin
            ack_pend_d       = ack_pend_q;
         end
         if (mret_i) begin
            mret_pend_d = 1'b1;
         end else begin
            mret_pend_d = mret_pend_q;
         end
      end else if (ack_pend_q) begin
         serve_ack_s      = 1'b1;
         serve_level_s    = ack_pend_level_q;
         ack_pend_d       = irq_ack_i;
         ack_pend_level_d = irq_ack_i ? irq_level_i : ack_pend_level_q;
         mret_pend_d      = mret_pend_q | mret_i;
      end else if (mret_pend_q) begin
         serve_mret_s     = 1'b1;
         mret_pend_d      = mret_i;
         ack_pend_d       = irq_ack_i;
         ack_pend_level_d = irq_ack_i ? irq_level_i : ack_pend_level_q;
      end else if (irq_ack_i) begin
         serve_ack_s      = 1'b1;
         serve_level_s    = irq_level_i;
         mret_pend_d      = mret_i;
      end else begin
         serve_mret_s     = mret_i;
      end

      if (serve_ack_s) begin
         if (depth_d == DepthW'(MaxDepth)) begin
            overflow_d = 1'b1;
`ifdef RT_IBEX_PCS_CTRL_LEVEL_CHECK_EN
         end else if ((depth_d != '0) && (serve_level_s <= curr_level_d)) begin
            level_err_d = 1'b1;
`endif
         end else begin
            state_d      = SAVE;
            save_level_d = serve_level_s;
         end
      end else if (serve_mret_s) begin
         if (depth_d == '0) begin
            underflow_d = 1'b1;
         end else begin
            state_d = POP;
         end
      end else begin
         level_err_d = level_err_d;
      end
   end

   // State and bookkeeping registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q          <= IDLE;
         depth_q          <= '0;
         level_stack_q    <= '{default: '0};
         curr_level_q     <= '0;
         save_level_q     <= '0;
         ack_pend_q       <= 1'b0;
         ack_pend_level_q <= '0;
         mret_pend_q      <= 1'b0;
         overflow_q       <= 1'b0;
         underflow_q      <= 1'b0;
         level_err_q      <= 1'b0;
      end else begin
         state_q          <= state_d;
         depth_q          <= depth_d;
         level_stack_q    <= level_stack_d;
         curr_level_q     <= curr_level_d;
         save_level_q     <= save_level_d;
         ack_pend_q       <= ack_pend_d;
         ack_pend_level_q <= ack_pend_level_d;
         mret_pend_q      <= mret_pend_d;
         overflow_q       <= overflow_d;
         underflow_q      <= underflow_d;
         level_err_q      <= level_err_d;
      end
   end

   assign push_o          = (state_q == SAVE);
   assign pop_o           = (state_q == POP);
   assign restore_valid_o = (state_q == WB);
   // Combinational so the core freezes in the very cycle the event appears.
   assign core_stall_o    = rst_ni & ((state_q != IDLE) | ack_pend_q | mret_pend_q |
                                      irq_ack_i | mret_i);
   assign depth_o         = depth_q;
   assign curr_level_o    = curr_level_q;
   assign overflow_o      = overflow_q;
   assign underflow_o     = underflow_q;
`ifdef RT_IBEX_PCS_CTRL_LEVEL_CHECK_EN
   assign level_err_o     = level_err_q;
`endif

endmodule
